// File: rtl/apb_uart_regif.sv
// APB3 slave register interface for a UART core: DATA/STATUS/DVSR registers,
// one-cycle FIFO strobes, PSLVERR on illegal access. Optional IRQ_EN via UART_IRQ_EN.
module apb_uart_regif #(
  parameter int                ADDR_W      = 32,
  parameter int                WAIT_STATES = 0,
  parameter int                DVSR_W      = 11,
  parameter logic [DVSR_W-1:0] DVSR_RST    = DVSR_W'(650)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              rd_uart,
  input  logic [7:0]        r_data,
  input  logic              tx_full,
  input  logic              rx_empty,
  output logic [DVSR_W-1:0] dvsr,
  output logic              irq
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              bad_q, bad_d;
  logic [1:0]        idx_q, idx_d;
  logic [DVSR_W-1:0] wdata_q, wdata_d;
  logic [DVSR_W-1:0] dvsr_q, dvsr_d;
  logic              ovr_q, ovr_d;
  logic              udr_q, udr_d;

  logic              commit, idx_ok, is_data, err;
  logic [31:0]       rd_mux;
  logic              unused_bits;

  // Only the bits the register map can ever use are captured at setup.
  assign unused_bits = ^{PWDATA[31:DVSR_W], PADDR[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    bad_d   = bad_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          wr_d    = PWRITE;
          bad_d   = |PADDR[ADDR_W-1:4];
          idx_d   = PADDR[3:2];
          wdata_d = PWDATA[DVSR_W-1:0];
          cnt_d   = 3'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_q != 3'd0) begin
          if (PENABLE) cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign PREADY = (state_q == ACCESS) && (cnt_q == 3'd0);
  // An aborted transfer (PSEL dropped) must never reach the commit path.
  assign commit = PREADY && PSEL && PENABLE;

`ifdef UART_IRQ_EN
  logic [2:0] en_q, en_d;
  logic       irq_q, irq_d;
  assign idx_ok = 1'b1;
`else
  assign idx_ok = (idx_q != 2'd3);
`endif

  assign is_data = !bad_q && (idx_q == 2'd0);
  assign err     = bad_q || !idx_ok
                || (is_data && wr_q && tx_full)
                || (is_data && !wr_q && rx_empty);

  always_comb begin
    rd_mux = 32'd0;
    case (idx_q)
      2'd0: rd_mux = {24'd0, r_data};
      2'd1: rd_mux = {28'd0, udr_q, ovr_q, tx_full, rx_empty};
      2'd2: rd_mux = 32'(dvsr_q);
`ifdef UART_IRQ_EN
      2'd3: rd_mux = {29'd0, en_q};
`endif
      default: rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    dvsr_d = dvsr_q;
    ovr_d  = ovr_q;
    udr_d  = udr_q;
`ifdef UART_IRQ_EN
    en_d   = en_q;
`endif
    if (commit) begin
      if (err) begin
        if (is_data && wr_q && tx_full)   ovr_d = 1'b1;
        if (is_data && !wr_q && rx_empty) udr_d = 1'b1;
      end else if (wr_q) begin
        case (idx_q)
          2'd1: begin
            if (wdata_q[2]) ovr_d = 1'b0;
            if (wdata_q[3]) udr_d = 1'b0;
          end
          2'd2: dvsr_d = wdata_q;
`ifdef UART_IRQ_EN
          2'd3: en_d = wdata_q[2:0];
`endif
          default: ;
        endcase
      end
    end
  end

  assign PSLVERR = commit && err;
  assign PRDATA  = (commit && !err && !wr_q) ? rd_mux : 32'd0;
  assign wr_uart = commit && !err && wr_q && is_data;
  assign rd_uart = commit && !err && !wr_q && is_data;
  assign w_data  = wr_uart ? wdata_q[7:0] : 8'd0;
  assign dvsr    = dvsr_q;

`ifdef UART_IRQ_EN
  always_comb begin
    irq_d = (en_q[0] && !rx_empty) || (en_q[1] && !tx_full)
         || (en_q[2] && (ovr_q || udr_q));
  end
  assign irq = irq_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en_q  <= 3'd0;
      irq_q <= 1'b0;
    end else begin
      en_q  <= en_d;
      irq_q <= irq_d;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= 2'd0;
      wdata_q <= '0;
      dvsr_q  <= DVSR_RST;
      ovr_q   <= 1'b0;
      udr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      bad_q   <= bad_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      dvsr_q  <= dvsr_d;
      ovr_q   <= ovr_d;
      udr_q   <= udr_d;
    end
  end

endmodule

// File: tb/tb_apb_uart_regif.sv
// Scoreboard bench for apb_uart_regif: two instances (0 and 3 wait states)
// share the APB bus; the driver queues expected completions, monitors compare.
module tb_apb_uart_regif;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        psel0, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [7:0]  r_data;
  logic        tx_full, rx_empty;

  logic [31:0] prdata0, prdata3;
  logic        rdy0, rdy3, err0, err3, wr0, wr3, rd0, rd3, irq0, irq3;
  logic [7:0]  wd0, wd3;
  logic [10:0] dvsr0, dvsr3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        wr;
    logic        rd;
    logic [7:0]  wdata;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];

  int checks = 0;
  int errors = 0;
  int wr_seen = 0, rd_seen = 0, wr_exp = 0, rd_exp = 0;

  always #5 PCLK = ~PCLK;

  apb_uart_regif #(.WAIT_STATES(0)) u0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0),
    .PREADY(rdy0), .PSLVERR(err0), .wr_uart(wr0), .w_data(wd0), .rd_uart(rd0),
    .r_data(r_data), .tx_full(tx_full), .rx_empty(rx_empty), .dvsr(dvsr0), .irq(irq0)
  );

  apb_uart_regif #(.WAIT_STATES(3)) u3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata3),
    .PREADY(rdy3), .PSLVERR(err3), .wr_uart(wr3), .w_data(wd3), .rd_uart(rd3),
    .r_data(r_data), .tx_full(tx_full), .rx_empty(rx_empty), .dvsr(dvsr3), .irq(irq3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic rdy, input logic [31:0] prd,
                          input logic er, input logic w, input logic r,
                          input logic [7:0] wd, input logic [10:0] dv, input logic iq);
    chk({tag, "_pready"}, {31'd0, rdy}, 32'd0);
    chk({tag, "_prdata"}, prd, 32'd0);
    chk({tag, "_pslverr"}, {31'd0, er}, 32'd0);
    chk({tag, "_strobes"}, {30'd0, w, r}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, wd}, 32'd0);
    chk({tag, "_dvsr"}, {21'd0, dv}, 32'd650);
    chk({tag, "_irq"}, {31'd0, iq}, 32'd0);
  endtask

  task automatic mon_cmp(input string tag, input exp_t e, input logic [31:0] prd,
                         input logic er, input logic w, input logic r, input logic [7:0] wd);
    chk({tag, "_prdata"}, prd, e.rdata);
    chk({tag, "_pslverr"}, {31'd0, er}, {31'd0, e.err});
    chk({tag, "_wr_uart"}, {31'd0, w}, {31'd0, e.wr});
    chk({tag, "_rd_uart"}, {31'd0, r}, {31'd0, e.rd});
    chk({tag, "_w_data"}, {24'd0, wd}, {24'd0, e.wdata});
  endtask

  // Monitor: compares every completion against the queued expectation.
  always @(negedge PCLK) begin
    exp_t e;
    if (rdy0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_unexpected_ready: got PREADY=1 expected no transfer");
      end else begin
        e = q0.pop_front();
        mon_cmp("u0", e, prdata0, err0, wr0, rd0, wd0);
      end
    end else if (wr0 || rd0 || err0 || prdata0 != 32'd0) begin
      checks++; errors++;
      $display("FAIL u0_idle_outputs: got wr=%0b rd=%0b err=%0b prdata=0x%08h expected all 0",
               wr0, rd0, err0, prdata0);
    end
    if (rdy3) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL u3_unexpected_ready: got PREADY=1 expected no transfer");
      end else begin
        e = q3.pop_front();
        mon_cmp("u3", e, prdata3, err3, wr3, rd3, wd3);
      end
    end else if (wr3 || rd3 || err3 || prdata3 != 32'd0) begin
      checks++; errors++;
      $display("FAIL u3_idle_outputs: got wr=%0b rd=%0b err=%0b prdata=0x%08h expected all 0",
               wr3, rd3, err3, prdata3);
    end
    wr_seen += int'(wr0) + int'(wr3);
    rd_seen += int'(rd0) + int'(rd3);
  end

  task automatic xfer(input int inst, input bit w, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input bit exp_err, input bit exp_wr, input bit exp_rdstb);
    exp_t e;
    int   cyc;
    bit   done;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.wr    = exp_wr;
    e.rd    = exp_rdstb;
    e.wdata = exp_wr ? wd[7:0] : 8'd0;
    wr_exp += int'(exp_wr);
    rd_exp += int'(exp_rdstb);
    @(posedge PCLK); #1;
    if (inst == 0) begin psel0 = 1'b1; q0.push_back(e); end
    else           begin psel3 = 1'b1; q3.push_back(e); end
    penable = 1'b0; pwrite = w; paddr = addr; pwdata = wd;
    @(posedge PCLK); #1;
    penable = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge PCLK);
      cyc++;
      if ((inst == 0) ? rdy0 : rdy3) done = 1'b1;
      else begin @(posedge PCLK); #1; end
    end
    chk($sformatf("u%0d_access_cycles", inst), cyc, (inst == 0) ? 1 : 4);
    @(posedge PCLK); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    PRESETn = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0; r_data = 8'd0; tx_full = 1'b0; rx_empty = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    chk_idle("rst_u0", rdy0, prdata0, err0, wr0, rd0, wd0, dvsr0, irq0);
    chk_idle("rst_u3", rdy3, prdata3, err3, wr3, rd3, wd3, dvsr3, irq3);
    PRESETn = 1'b1;

    xfer(0, 1, 32'h00, 32'h0000_00A5, 32'h0, 0, 1, 0);

    r_data = 8'h3C; rx_empty = 1'b0;
    xfer(3, 0, 32'h00, 32'h0, 32'h0000_003C, 0, 0, 1);

    tx_full = 1'b1;
    xfer(0, 1, 32'h00, 32'h0000_0077, 32'h0, 1, 0, 0);
    xfer(0, 0, 32'h04, 32'h0, 32'h6, 0, 0, 0);
    xfer(0, 1, 32'h04, 32'h4, 32'h0, 0, 0, 0);
    xfer(0, 0, 32'h04, 32'h0, 32'h2, 0, 0, 0);

    rx_empty = 1'b1;
    xfer(0, 0, 32'h00, 32'h0, 32'h0, 1, 0, 0);
    xfer(0, 0, 32'h04, 32'h0, 32'hB, 0, 0, 0);
    xfer(0, 1, 32'h04, 32'h8, 32'h0, 0, 0, 0);
    xfer(0, 0, 32'h04, 32'h0, 32'h3, 0, 0, 0);
    tx_full = 1'b0;

    xfer(0, 1, 32'h08, 32'h0000_0145, 32'h0, 0, 0, 0);
    chk("u0_dvsr_after_write", {21'd0, dvsr0}, 32'h145);
    xfer(0, 0, 32'h08, 32'h0, 32'h0000_0145, 0, 0, 0);
    xfer(0, 0, 32'h10, 32'h0, 32'h0, 1, 0, 0);
    xfer(0, 1, 32'h10, 32'h0000_0033, 32'h0, 1, 0, 0);
    chk("u0_dvsr_after_bad_write", {21'd0, dvsr0}, 32'h145);

`ifdef UART_IRQ_EN
    xfer(0, 1, 32'h0C, 32'h1, 32'h0, 0, 0, 0);
    @(negedge PCLK);
    chk("u0_irq_rx_empty", {31'd0, irq0}, 32'd0);
    @(posedge PCLK); #1;
    rx_empty = 1'b0;
    @(negedge PCLK);
    chk("u0_irq_same_cycle", {31'd0, irq0}, 32'd0);
    @(negedge PCLK);
    chk("u0_irq_next_cycle", {31'd0, irq0}, 32'd1);
    xfer(0, 0, 32'h0C, 32'h0, 32'h1, 0, 0, 0);
    rx_empty = 1'b1;
`else
    xfer(0, 1, 32'h0C, 32'h1, 32'h0, 1, 0, 0);
    xfer(0, 0, 32'h0C, 32'h0, 32'h0, 1, 0, 0);
    rx_empty = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("u0_irq_tied_low", {31'd0, irq0}, 32'd0);
    rx_empty = 1'b1;
`endif

    // Reset in the middle of a wait-stated access on u3.
    @(posedge PCLK); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h11;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #1;
    chk_idle("midrst_u3", rdy3, prdata3, err3, wr3, rd3, wd3, dvsr3, irq3);
    chk("midrst_u0_dvsr", {21'd0, dvsr0}, 32'd650);
    @(posedge PCLK); #1;
    psel3 = 1'b0; penable = 1'b0;
    PRESETn = 1'b1;

    xfer(3, 1, 32'h00, 32'h0000_005A, 32'h0, 0, 1, 0);
    xfer(3, 1, 32'h08, 32'h0000_00AB, 32'h0, 0, 0, 0);
    chk("u3_dvsr_after_write", {21'd0, dvsr3}, 32'hAB);

    repeat (2) @(posedge PCLK);
    chk("queue_u0_drained", q0.size(), 0);
    chk("queue_u3_drained", q3.size(), 0);
    chk("wr_uart_pulses", wr_seen, wr_exp);
    chk("rd_uart_pulses", rd_seen, rd_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_uart_regif.md
Name: apb_uart_regif

Overview:
- APB3 slave register interface that sits between the APB master and the UART core (FIFOs plus baud generator).
- Decodes APB transfers into one-cycle UART FIFO strobes (wr_uart, rd_uart), carries byte data in both directions, and exposes status and baud-divisor registers.
- Reports illegal accesses with PSLVERR. The master consumes PREADY, PRDATA and PSLVERR directly.

Parameters:
- ADDR_W, 32, PADDR width; only PADDR[3:2] is decoded, PADDR[ADDR_W-1:4] must be zero.
- WAIT_STATES, 0, extra access-phase cycles with PREADY low (legal 0..7).
- DVSR_W, 11, baud divisor width.
- DVSR_RST, 11'd650, divisor reset value.

Ports:
- PCLK input 1 APB clock, also the UART clock.
- PRESETn input 1 asynchronous active-low reset.
- PSEL input 1 slave select.
- PENABLE input 1 access phase.
- PWRITE input 1 1=write, 0=read.
- PADDR input ADDR_W byte address.
- PWDATA input 32 write data.
- PRDATA output 32 read data, valid while PREADY=1.
- PREADY output 1 transfer complete.
- PSLVERR output 1 error response, valid while PREADY=1.
- wr_uart output 1 one-cycle TX FIFO push.
- w_data output 8 TX byte, valid with wr_uart.
- rd_uart output 1 one-cycle RX FIFO pop.
- r_data input 8 RX FIFO head (first-word-fall-through).
- tx_full input 1 TX FIFO full.
- rx_empty input 1 RX FIFO empty.
- dvsr output DVSR_W baud divisor to the baud generator.
- irq output 1 interrupt (tied 0 unless UART_IRQ_EN).

Behaviour:
- Reset: async on PRESETn=0. State=IDLE; PRDATA=0, PREADY=0, PSLVERR=0, wr_uart=0, rd_uart=0, w_data=0; dvsr=DVSR_RST; sticky flags=0; irq=0.
- FSM states: IDLE, ACCESS.
  - IDLE: on PSEL=1 and PENABLE=0 (setup phase), latch address, direction and PWDATA; load wait counter with WAIT_STATES; go to ACCESS.
  - ACCESS: while PSEL=1 and PENABLE=1 and counter>0, decrement the counter with PREADY=0.
  - ACCESS: when counter=0, drive PREADY=1 combinationally from state and counter, commit the access, return to IDLE.
  - ACCESS: if PSEL drops before completion, abort to IDLE with no side effects.
  - A zero-wait transfer takes 2 cycles. Back-to-back transfers always pass through a new setup cycle.
- Register map (byte offsets):
  - 0x00 DATA.
    - Write: w_data=PWDATA[7:0] and wr_uart pulse in the PREADY cycle.
    - Read: PRDATA={24'b0,r_data} and rd_uart pulse in the PREADY cycle.
  - 0x04 STATUS.
    - Bit0=rx_empty, bit1=tx_full, bit2=TX overrun sticky, bit3=RX underrun sticky; other bits read 0.
    - Write with 1 clears bits 3:2 (W1C); other bits are ignored.
  - 0x08 DVSR: read/write of [DVSR_W-1:0]; upper bits read 0. The new value appears on dvsr the cycle after PREADY.
  - 0x0C: IRQ_EN (only with UART_IRQ_EN), else error.
- Errors: PSLVERR=1 with PREADY=1, no strobe, and no register change for any of:
  - an undecoded address;
  - a DATA write while tx_full=1 (sets overrun bit);
  - a DATA read while rx_empty=1 (sets underrun bit; PRDATA=0).
- Full/empty flags are sampled in the PREADY cycle, not the setup cycle.
- A W1C write and a same-cycle sticky set cannot coincide, because only one transfer is active at a time.
- PRDATA=0 whenever PREADY=0.
- Strobes fire exactly once per completed transfer and never during wait states.
- Reset asserted mid-transfer returns to IDLE immediately with strobes low.

Optional Feature:
- Macro: UART_IRQ_EN.
- Defined:
  - Adds IRQ_EN register at 0x0C: bit0=RX not-empty enable, bit1=TX not-full enable, bit2=error enable; reset value 0.
  - irq is registered: irq = (en0 & ~rx_empty) | (en1 & ~tx_full) | (en2 & (ovr|udr)), one-cycle latency.
- Undefined: 0x0C returns PSLVERR and irq is constant 0.

Test Plan:
- Reset with PRESETn=0 mid-ACCESS -> all outputs 0, dvsr=650; the first transfer after release completes normally.
- WAIT_STATES=0, write 0x000000A5 to 0x00 with tx_full=0 -> PREADY high on cycle 2, wr_uart one cycle, w_data=0xA5, PSLVERR=0.
- WAIT_STATES=3, read 0x00 with r_data=0x3C, rx_empty=0 -> PREADY high in the 4th access cycle, PRDATA=0x0000003C, single rd_uart pulse.
- Write to 0x00 with tx_full=1 -> PSLVERR=1, no wr_uart, then STATUS reads 0x6 with tx_full still 1; writing 0x4 to STATUS clears bit2.
- Write 0x145 to 0x08, read back -> dvsr=0x145, PRDATA=0x00000145; access 0x10 -> PSLVERR=1.
- UART_IRQ_EN defined, IRQ_EN=0x1, rx_empty goes 1->0 -> irq=1 one cycle later; undefined build: 0x0C gives PSLVERR and irq stays 0.
